seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Parametrised sequential shift-and-add multiplier. Successor to the combinational 8-bit adder in the Multiplier directory.
Multiplies two WIDTH-bit operands over WIDTH iterations using one WIDTH-bit adder, with a start/ready/done handshake.
Sits between the SPI datapath and its register file: the controller loads operands, pulses start, and reads product on done.

Parameters:
WIDTH, 8, operand width in bits; legal range is WIDTH >= 2; product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden

Ports:
clk  input  1  system clock; rising-edge active
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when ready=1
a  input  WIDTH  multiplicand; captured on the accepted start edge
b  input  WIDTH  multiplier; captured on the accepted start edge
ready  output  1  high in IDLE; reset 1
busy  output  1  high in RUN; reset 0
done  output  1  one-cycle pulse in DONE; reset 0
product  output  2*WIDTH  result; reset 0; holds its value until the next accepted start

Behaviour:
- Reset: asynchronous on rst_n=0, regardless of state.
  - State=IDLE; accumulator, shift register, counter and product cleared to 0.
  - Outputs go to their reset values immediately, not at the next edge.
- States: IDLE, RUN, DONE. Encoding comes from the package.
  - IDLE -> RUN on an edge with start=1.
  - RUN -> DONE on the edge where counter reaches WIDTH.
  - DONE -> IDLE on the next edge, unconditionally.
- Start accept (edge 0):
  - Latch a into the multiplicand register.
  - Load b into the low half of a 2*WIDTH shift register P; high half = 0.
  - Counter = 0.
- RUN iteration (edges 1..WIDTH), each edge:
  - If P[0]=1: sum = P[2W-1:W] + mcand, with WIDTH+1-bit result (carry kept). Else sum = {1'b0, P[2W-1:W]}.
  - P <= {sum, P[W-1:1]}; counter increments.
- Result timing:
  - product <= P on the transition into DONE.
  - done=1 for exactly one cycle, the cycle after edge WIDTH.
  - Latency from start edge to done high = WIDTH+1 edges.
- start while RUN or DONE: ignored, with no side effects; the operands must not be re-latched.
- Back-to-back: start asserted in the IDLE cycle following DONE is accepted.
- Arithmetic: unsigned; the full 2*WIDTH product is kept, so overflow is impossible.
- Operand 0: still takes the full WIDTH iterations; product = 0. There is no early exit.
- Reset mid-RUN: partial result is discarded; product returns to 0.

Optional Feature:
MULT_SIGNED_EN
- Defined: operands are two's complement.
  - At accept, store |a| and |b| and a sign flag, neg = a[W-1]^b[W-1].
  - On entry to DONE, product = neg ? -P : P (2*WIDTH-bit two's complement).
  - Latency is unchanged.
  - Most negative operand: magnitude is computed in WIDTH+1 bits so that -2^(W-1) is handled exactly.
- Undefined: purely unsigned as above; no sign logic is synthesised.

Decomposition:
- Shared package mult_pkg contains:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - localparam for the DONE-pulse length (1)
- Sub-module adder_n, parametrised by WIDTH:
  - Ports: in0, in1, sum, carry out.
  - Purely combinational; generalises the existing 8-bit adder.
  - Instantiated once for the accumulate step.

Test Plan:
- WIDTH=8, a=4, b=1, start one cycle -> ready drops; done high exactly at edge 9; product=16'd4; ready=1 the next cycle.
- a=8, b=4 -> product=16'd32. Then a=255, b=255 issued back-to-back in the cycle after done -> product=16'hFE01.
- Start with a=6, b=7; pulse start with a=1, b=1 at edge 3 -> ignored; product=16'd42 at edge 9.
- Start a=200, b=3; drive rst_n=0 mid-edge 4 -> busy=0, product=0, ready=1 immediately. Next op a=2, b=3 -> product=6.
- WIDTH=4, a=0, b=15 -> done at edge 5, product=8'd0. a=15, b=15 -> product=8'd225.
- MULT_SIGNED_EN, WIDTH=8:
  - a=-3, b=5 -> product=16'hFFF1
  - a=-128, b=-128 -> product=16'h4000
  - a=-128, b=1 -> product=16'hFF80

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and
// DONE pulse length.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DONE_PULSE_LEN = 1;

endpackage

// File: rtl/adder_n.sv
// WIDTH-bit ripple adder with carry out; used once for the accumulate step.
module adder_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, in0} + {1'b0, in1};

endmodule

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier, WIDTH iterations per product, start/ready/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     acc_sum;
  logic                 acc_carry;
  logic [2*WIDTH-1:0]   p_step;
  logic [WIDTH-1:0]     a_load, b_load;
  logic [2*WIDTH-1:0]   p_result;

  assign addend = p_q[0] ? mcand_q : '0;

  adder_n #(.WIDTH(WIDTH)) u_adder (
    .in0  (p_q[2*WIDTH-1:WIDTH]),
    .in1  (addend),
    .sum  (acc_sum),
    .cout (acc_carry)
  );

  assign p_step = {acc_carry, acc_sum, p_q[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Widened by one bit so the most negative operand maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] ext;
    ext = {v[WIDTH-1], v};
    if (v[WIDTH-1]) ext = '0 - ext;
    return ext[WIDTH-1:0];
  endfunction

  assign a_load   = magnitude(a);
  assign b_load   = magnitude(b);
  assign p_result = neg_q ? ('0 - p_step) : p_step;
`else
  assign a_load   = a;
  assign b_load   = b;
  assign p_result = p_step;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a_load;
          p_d     = {{WIDTH{1'b0}}, b_load};
          cnt_d   = '0;
`ifdef MULT_SIGNED_EN
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = p_result;
          // Counter is reused to time the DONE pulse.
          cnt_d     = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DONE_PULSE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed plus random checks of seq_multiplier at WIDTH=8 and WIDTH=4
// against an arithmetic reference product.
module tb_seq_multiplier;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, busy8, done8;
  logic [15:0] product8;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ready4, busy4, done4;
  logic [7:0]  product4;

  int vectors = 0;
  int miscompares = 0;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .product(product4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
    int p;
`ifdef MULT_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[15:0];
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y);
    int p;
`ifdef MULT_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts in an IDLE cycle, ends in the IDLE cycle after DONE.
  // poke re-asserts start with new operands partway through RUN.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input string tag, input bit poke);
    logic [15:0] prev;
    int n;
    int k;
    prev = product8;
    n = 0;
    k = 0;
    chk({tag, " ready_idle"}, 32'(ready8), 32'd1);
    a8 = ia; b8 = ib; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk({tag, " busy"}, 32'(busy8), 32'd1);
    chk({tag, " ready_run"}, 32'(ready8), 32'd0);
    chk({tag, " product_hold"}, 32'(product8), 32'(prev));
    while (!done8 && n < 40) begin
      if (poke && n == 2) begin
        start8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      end else begin
        start8 = 1'b0;
      end
      step();
      n++;
    end
    start8 = 1'b0;
    // done rises WIDTH edges after the accept edge (WIDTH+1 edges counting it)
    chk({tag, " latency"}, 32'(n), 32'd8);
    chk({tag, " product"}, 32'(product8), 32'(ref8(ia, ib)));
    while (done8 && k < 8) begin
      step();
      k++;
    end
    chk({tag, " done_len"}, 32'(k), 32'(DONE_PULSE_LEN));
    chk({tag, " ready_after"}, 32'(ready8), 32'd1);
    chk({tag, " product_kept"}, 32'(product8), 32'(ref8(ia, ib)));
  endtask

  task automatic run4(input logic [3:0] ia, input logic [3:0] ib, input string tag);
    int n;
    n = 0;
    chk({tag, " ready_idle"}, 32'(ready4), 32'd1);
    a4 = ia; b4 = ib; start4 = 1'b1;
    step();
    start4 = 1'b0;
    chk({tag, " busy"}, 32'(busy4), 32'd1);
    while (!done4 && n < 20) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd4);
    chk({tag, " product"}, 32'(product4), 32'(ref4(ia, ib)));
    step();
    chk({tag, " done_drop"}, 32'(done4), 32'd0);
    chk({tag, " ready_after"}, 32'(ready4), 32'd1);
  endtask

  initial begin
    #2;
    chk("rst ready8", 32'(ready8), 32'd1);
    chk("rst busy8", 32'(busy8), 32'd0);
    chk("rst done8", 32'(done8), 32'd0);
    chk("rst product8", 32'(product8), 32'd0);
    chk("rst ready4", 32'(ready4), 32'd1);
    chk("rst product4", 32'(product4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run8(8'd4, 8'd1, "w8_4x1", 1'b0);
    run8(8'd8, 8'd4, "w8_8x4", 1'b0);
    run8(8'd255, 8'd255, "w8_ffxff_b2b", 1'b0);
    run8(8'd6, 8'd7, "w8_6x7_ignore", 1'b1);
    run8(8'hFD, 8'd5, "w8_m3x5", 1'b0);
    run8(8'h80, 8'h80, "w8_minxmin", 1'b0);
    run8(8'h80, 8'd1, "w8_minx1", 1'b0);

    // Asynchronous reset in the middle of RUN
    a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    chk("midrst busy_before", 32'(busy8), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst ready", 32'(ready8), 32'd1);
    chk("midrst done", 32'(done8), 32'd0);
    chk("midrst product", 32'(product8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run8(8'd2, 8'd3, "w8_after_rst", 1'b0);

    run4(4'd0, 4'd15, "w4_0x15");
    run4(4'd15, 4'd15, "w4_15x15");
    run4(4'h8, 4'h8, "w4_minxmin");
    for (int i = 0; i < 8; i++) begin
      run4(4'($urandom), 4'($urandom), "w4_rand");
    end

    for (int i = 0; i < 20; i++) begin
      run8(8'($urandom), 8'($urandom), "w8_rand", 1'($urandom_range(0, 1)));
    end
    run8(8'd0, 8'd0, "w8_0x0", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
